// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared types and widths for the MAX10 ADC scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

  localparam int ADC_DATA_W = 12;  // ADC sample width
  localparam int ADC_CH_W   = 5;   // Avalon-ST channel field width
  localparam int CH_IDX_W   = 3;   // logical channel index width (up to 8 channels)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    CMD  = 2'd2,
    WAIT = 2'd3
  } seq_state_t;

endpackage : adc_pkg
`default_nettype wire

// File: rtl/adc_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : adc_rr_pick
// Description : Combinational round-robin picker. Returns the first enabled
//               channel strictly after i_last, wrapping at NUM_CH. When only
//               i_last itself is enabled, it is picked again.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_rr_pick #(
  parameter int NUM_CH = 8,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [IDX_W-1:0]  i_last,
  output logic [IDX_W-1:0]  o_next,
  output logic              o_found
);

  logic [IDX_W-1:0] w_idx;

  // Scan from farthest to nearest so the nearest enabled channel wins last
  always_comb begin
    o_next  = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      w_idx = IDX_W'((int'(i_last) + i) % NUM_CH);
      if (i_mask[w_idx]) begin
        o_next  = w_idx;
        o_found = 1'b1;
      end
    end
  end

endmodule : adc_rr_pick
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_sequencer
// Description : Round-robin scanner in front of the MAX10 modular ADC command
//               port. One command outstanding at a time; each matching
//               response is stored in a per-channel result file.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CH_OFFSET   = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  scan_en,
  input  logic [NUM_CH-1:0]     ch_mask,
  output logic                  cmd_valid,
  output logic [ADC_CH_W-1:0]   cmd_channel,
  output logic                  cmd_sop,
  output logic                  cmd_eop,
  input  logic                  cmd_ready,
  input  logic                  rsp_valid,
  input  logic [ADC_CH_W-1:0]   rsp_channel,
  input  logic [ADC_DATA_W-1:0] rsp_data,
  output logic                  smp_valid,
  output logic [CH_IDX_W-1:0]   smp_ch,
  output logic [ADC_DATA_W-1:0] smp_data,
  input  logic [CH_IDX_W-1:0]   rd_ch,
  output logic [ADC_DATA_W-1:0] rd_data,
  output logic                  scan_done,
  output logic                  err_timeout,
  output logic                  err_chan,
  input  logic                  err_clr
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);

  seq_state_t              r_state;
  seq_state_t              w_state_nxt;
  logic [CH_IDX_W-1:0]     r_last;
  logic [CH_IDX_W-1:0]     r_cur;
  logic [ADC_CH_W-1:0]     r_cmd_channel;
  logic [TIMER_W-1:0]      r_timer;
  logic                    r_smp_valid;
  logic [CH_IDX_W-1:0]     r_smp_ch;
  logic [ADC_DATA_W-1:0]   r_smp_data;
  logic                    r_scan_done;
  logic                    r_err_timeout;
  logic                    r_err_chan;
  logic [ADC_DATA_W-1:0]   r_rf [NUM_CH];

  logic [CH_IDX_W-1:0]     w_pick_next;
  logic                    w_pick_found;
  logic [CH_IDX_W-1:0]     w_top_ch;
  logic                    w_cmd_valid;
  logic                    w_handshake;
  logic                    w_accept;
  logic                    w_rsp_bad;
  logic                    w_timeout;
  logic                    w_pass_end;

  adc_rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_IDX_W)
  ) u_pick (
    .i_mask  (ch_mask),
    .i_last  (r_last),
    .o_next  (w_pick_next),
    .o_found (w_pick_found)
  );

  // Highest enabled channel marks the end of a scan pass
  always_comb begin
    w_top_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_mask[i]) w_top_ch = CH_IDX_W'(i);
    end
  end

  // Next-state decode and per-cycle strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_valid = 1'b0;
    w_handshake = 1'b0;
    w_accept    = 1'b0;
    w_rsp_bad   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (scan_en && (|ch_mask)) w_state_nxt = PICK;
      end
      PICK: begin
        w_state_nxt = w_pick_found ? CMD : IDLE;
      end
      CMD: begin
        // A command, once presented, stays up until accepted
        w_cmd_valid = 1'b1;
        if (cmd_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (rsp_valid && (rsp_channel == r_cmd_channel)) begin
          w_accept = 1'b1;
        end else begin
          w_rsp_bad = rsp_valid;
          w_timeout = (r_timer == TIMER_W'(TIMEOUT_CYC));
        end
        if (w_accept || w_timeout) w_state_nxt = scan_en ? PICK : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_pass_end = (w_accept || w_timeout) && (r_cur == w_top_ch) && ch_mask[r_cur];

  // State register
  always_ff @(posedge sys_clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Channel bookkeeping and response timer
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_last        <= CH_IDX_W'(NUM_CH - 1);
      r_cur         <= '0;
      r_cmd_channel <= '0;
      r_timer       <= '0;
    end else begin
      if ((r_state == PICK) && w_pick_found) begin
        r_cur         <= w_pick_next;
        r_cmd_channel <= ADC_CH_W'(w_pick_next) + ADC_CH_W'(CH_OFFSET);
      end
      if (w_handshake)           r_timer <= '0;
      else if (r_state == WAIT)  r_timer <= r_timer + 1'b1;
      if (w_accept || w_timeout) r_last  <= r_cur;
    end
  end

  // Sample output, result file and pass-complete pulse
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_smp_valid <= 1'b0;
      r_smp_ch    <= '0;
      r_smp_data  <= '0;
      r_scan_done <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_rf[i] <= '0;
    end else begin
      r_smp_valid <= w_accept;
      r_scan_done <= w_pass_end;
      if (w_accept) begin
        r_smp_ch     <= r_cur;
        r_smp_data   <= rsp_data;
        r_rf[r_cur]  <= rsp_data;
      end
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_err_timeout <= 1'b0;
      r_err_chan    <= 1'b0;
    end else begin
      if (w_timeout)    r_err_timeout <= 1'b1;
      else if (err_clr) r_err_timeout <= 1'b0;
      if (w_rsp_bad)    r_err_chan    <= 1'b1;
      else if (err_clr) r_err_chan    <= 1'b0;
    end
  end

  assign cmd_valid   = w_cmd_valid;
  assign cmd_channel = r_cmd_channel;
  assign cmd_sop     = 1'b1;
  assign cmd_eop     = 1'b1;
  assign smp_valid   = r_smp_valid;
  assign smp_ch      = r_smp_ch;
  assign smp_data    = r_smp_data;
  assign scan_done   = r_scan_done;
  assign err_timeout = r_err_timeout;
  assign err_chan    = r_err_chan;
  assign rd_data     = (int'(rd_ch) < NUM_CH) ? r_rf[rd_ch] : '0;

endmodule : adc_scan_sequencer
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_scan_sequencer
// Description : Directed self-checking bench for adc_scan_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        scan_en;
  logic [7:0]  ch_mask;
  logic        cmd_valid;
  logic [4:0]  cmd_channel;
  logic        cmd_sop;
  logic        cmd_eop;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [4:0]  rsp_channel;
  logic [11:0] rsp_data;
  logic        smp_valid;
  logic [2:0]  smp_ch;
  logic [11:0] smp_data;
  logic [2:0]  rd_ch;
  logic [11:0] rd_data;
  logic        scan_done;
  logic        err_timeout;
  logic        err_chan;
  logic        err_clr;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp_rf [8];
  logic        seen;

  always #5 sys_clk = ~sys_clk;

  adc_scan_sequencer #(
    .NUM_CH      (8),
    .CH_OFFSET   (1),
    .TIMEOUT_CYC (255)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .scan_en     (scan_en),
    .ch_mask     (ch_mask),
    .cmd_valid   (cmd_valid),
    .cmd_channel (cmd_channel),
    .cmd_sop     (cmd_sop),
    .cmd_eop     (cmd_eop),
    .cmd_ready   (cmd_ready),
    .rsp_valid   (rsp_valid),
    .rsp_channel (rsp_channel),
    .rsp_data    (rsp_data),
    .smp_valid   (smp_valid),
    .smp_ch      (smp_ch),
    .smp_data    (smp_data),
    .rd_ch       (rd_ch),
    .rd_data     (rd_data),
    .scan_done   (scan_done),
    .err_timeout (err_timeout),
    .err_chan    (err_chan),
    .err_clr     (err_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a command and check its channel
  task automatic wait_cmd(input logic [4:0] exp_ch);
    int i;
    i = 0;
    while (!cmd_valid && i < 40) begin
      @(negedge sys_clk);
      i++;
    end
    check_eq("cmd_valid_seen", {31'd0, cmd_valid}, 32'd1);
    check_eq("cmd_channel", {27'd0, cmd_channel}, {27'd0, exp_ch});
  endtask

  // Respond to the outstanding command three cycles after the handshake
  task automatic respond(input logic [2:0] ch, input logic [11:0] data, input logic exp_done);
    repeat (3) begin
      @(negedge sys_clk);
      check_eq("cmd_valid_in_wait", {31'd0, cmd_valid}, 32'd0);
    end
    rsp_valid   = 1'b1;
    rsp_channel = 5'(ch) + 5'd1;
    rsp_data    = data;
    rd_ch       = ch;
    #1;
    check_eq("rd_old_during_write", {20'd0, rd_data}, {20'd0, exp_rf[ch]});
    @(negedge sys_clk);
    rsp_valid  = 1'b0;
    exp_rf[ch] = data;
    check_eq("smp_valid", {31'd0, smp_valid}, 32'd1);
    check_eq("smp_ch", {29'd0, smp_ch}, {29'd0, ch});
    check_eq("smp_data", {20'd0, smp_data}, {20'd0, data});
    check_eq("scan_done", {31'd0, scan_done}, {31'd0, exp_done});
    check_eq("rd_new", {20'd0, rd_data}, {20'd0, data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) exp_rf[i] = 12'h000;
    reset = 1'b1; scan_en = 1'b0; ch_mask = 8'h00; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_channel = 5'd0; rsp_data = 12'h000; rd_ch = 3'd0; err_clr = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);

    // Reset state
    check_eq("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check_eq("rst_cmd_sop", {31'd0, cmd_sop}, 32'd1);
    check_eq("rst_cmd_eop", {31'd0, cmd_eop}, 32'd1);
    check_eq("rst_cmd_channel", {27'd0, cmd_channel}, 32'd0);
    check_eq("rst_smp_valid", {31'd0, smp_valid}, 32'd0);
    check_eq("rst_err", {30'd0, err_timeout, err_chan}, 32'd0);
    check_eq("rst_rd_data", {20'd0, rd_data}, 32'd0);

    // Latency from scan_en to cmd_valid, then round-robin over mask 0101
    ch_mask = 8'b0000_0101; scan_en = 1'b1; cmd_ready = 1'b1;
    @(negedge sys_clk);
    check_eq("lat_cyc1", {31'd0, cmd_valid}, 32'd0);
    @(negedge sys_clk);
    check_eq("lat_cyc2", {31'd0, cmd_valid}, 32'd1);
    wait_cmd(5'd1); respond(3'd0, 12'h111, 1'b0);
    wait_cmd(5'd3); respond(3'd2, 12'h222, 1'b1);
    wait_cmd(5'd1); respond(3'd0, 12'h333, 1'b0);
    wait_cmd(5'd3); respond(3'd2, 12'h444, 1'b1);
    rd_ch = 3'd0; #1; check_eq("rf_ch0", {20'd0, rd_data}, 32'h333);
    rd_ch = 3'd2; #1; check_eq("rf_ch2", {20'd0, rd_data}, 32'h444);
    rd_ch = 3'd1; #1; check_eq("rf_ch1", {20'd0, rd_data}, 32'h000);

    // Back-pressure: command held stable while cmd_ready is low
    cmd_ready = 1'b0;
    wait_cmd(5'd1);
    repeat (10) begin
      @(negedge sys_clk);
      check_eq("hold_cmd", {26'd0, cmd_valid, cmd_channel}, {26'd0, 1'b1, 5'd1});
    end
    cmd_ready = 1'b1;
    respond(3'd0, 12'h555, 1'b0);

    // Wrong-channel response is discarded and flagged
    wait_cmd(5'd3);
    @(negedge sys_clk);
    rsp_valid = 1'b1; rsp_channel = 5'd5; rsp_data = 12'hBAD; rd_ch = 3'd2;
    @(negedge sys_clk);
    rsp_valid = 1'b0;
    check_eq("bad_err_chan", {31'd0, err_chan}, 32'd1);
    check_eq("bad_smp_valid", {31'd0, smp_valid}, 32'd0);
    check_eq("bad_no_write", {20'd0, rd_data}, {20'd0, exp_rf[2]});
    respond(3'd2, 12'h666, 1'b1);

    // Lost response: timeout after TIMEOUT_CYC wait cycles
    wait_cmd(5'd1);
    repeat (256) @(negedge sys_clk);
    check_eq("tmo_early", {31'd0, err_timeout}, 32'd0);
    @(negedge sys_clk);
    check_eq("tmo_set", {31'd0, err_timeout}, 32'd1);
    check_eq("tmo_scan_done", {31'd0, scan_done}, 32'd0);
    check_eq("tmo_smp_valid", {31'd0, smp_valid}, 32'd0);
    rd_ch = 3'd0; #1;
    check_eq("tmo_no_write", {20'd0, rd_data}, {20'd0, exp_rf[0]});
    wait_cmd(5'd3);
    check_eq("err_chan_sticky", {31'd0, err_chan}, 32'd1);
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    check_eq("clr_err_timeout", {31'd0, err_timeout}, 32'd0);
    check_eq("clr_err_chan", {31'd0, err_chan}, 32'd0);
    // New error coincident with clear keeps the flag set
    rsp_valid = 1'b1; rsp_channel = 5'd5; rsp_data = 12'hBAD; err_clr = 1'b1;
    @(negedge sys_clk);
    rsp_valid = 1'b0; err_clr = 1'b0;
    check_eq("clr_vs_set", {31'd0, err_chan}, 32'd1);
    respond(3'd2, 12'h777, 1'b1);

    // scan_en dropped while a command is pending
    cmd_ready = 1'b0;
    wait_cmd(5'd1);
    scan_en = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      check_eq("cmd_not_withdrawn", {31'd0, cmd_valid}, 32'd1);
    end
    cmd_ready = 1'b1;
    respond(3'd0, 12'h888, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge sys_clk);
      if (cmd_valid) seen = 1'b1;
    end
    check_eq("stopped_no_cmd", {31'd0, seen}, 32'd0);

    // Empty mask with scan enabled
    ch_mask = 8'h00; scan_en = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge sys_clk);
      if (cmd_valid) seen = 1'b1;
    end
    check_eq("mask0_no_cmd", {31'd0, seen}, 32'd0);

    // Single top channel: wraps onto itself, every sample ends a pass
    ch_mask = 8'h80;
    wait_cmd(5'd8); respond(3'd7, 12'hABC, 1'b1);
    wait_cmd(5'd8);

    // Reset during WAIT with a response arriving in the same cycle
    @(negedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b1; scan_en = 1'b0;
    rsp_valid = 1'b1; rsp_channel = 5'd8; rsp_data = 12'hFFF;
    @(negedge sys_clk);
    rsp_valid = 1'b0;
    check_eq("wrst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check_eq("wrst_cmd_channel", {27'd0, cmd_channel}, 32'd0);
    check_eq("wrst_smp_valid", {31'd0, smp_valid}, 32'd0);
    check_eq("wrst_smp", {17'd0, smp_ch, smp_data}, 32'd0);
    check_eq("wrst_scan_done", {31'd0, scan_done}, 32'd0);
    check_eq("wrst_err", {30'd0, err_timeout, err_chan}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_ch = 3'(i); #1;
      check_eq("wrst_rd_data", {20'd0, rd_data}, 32'd0);
    end
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_adc_scan_sequencer
`default_nettype wire
